seq_divider8: RTL and testbench



---
 rtl/seq_divider8_if.sv | 25 ++
 rtl/seq_divider8.sv | 91 +++++++++
 tb/tb_seq_divider8.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider8_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master modport is the requesting side; the slave modport is the divider.
interface seq_divider8_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider8.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// operands and results exchanged over valid/ready handshakes.
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider8_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             dbz;
  logic             rdy;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   t;

  // Trial subtract; t[WIDTH] set means borrow, so the shifted value is kept.
  always_comb begin
    r = {rem, q[WIDTH-1]};
    t = r - {1'b0, dvsr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rdy       = 1'b0;
    last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:    rdy = rst_n;
      DONE:    rdy = rst_n & bus.out_ready;
      default: rdy = 1'b0;
    endcase
    accept = bus.in_valid & rdy;
    if (accept)
      state_nx = (bus.divisor == '0) ? DONE : CALC;
    else if (last_step)
      state_nx = DONE;
    else if ((state == DONE) && bus.out_ready)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      dbz  <= 1'b0;
    end else if (accept) begin
      dvsr <= bus.divisor;
      cnt  <= '0;
      if (bus.divisor == '0) begin
        q   <= '1;
        rem <= bus.dividend;
        dbz <= 1'b1;
      end else begin
        q   <= bus.dividend;
        rem <= '0;
        dbz <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      rem <= t[WIDTH] ? r[WIDTH-1:0] : t[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], ~t[WIDTH]};
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider8.sv
// Directed-vector bench for seq_divider8 with hand-computed results.
module tb_seq_divider8;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_divider8_if #(.WIDTH(8)) bus ();

  seq_divider8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t tbl [0:9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the divider ready; returns just after the accept edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded at 20.
  task automatic wait_valid(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
    check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int exp_lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(bus.quotient), 32'(v.q));
    check({tag, " remainder"}, 32'(bus.remainder), 32'(v.r));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(v.z));
  endtask

  initial begin
    int   lat;
    logic busy_ok;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    tbl[0] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
    tbl[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
    tbl[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
    tbl[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   z: 1'b0};
    tbl[4] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, z: 1'b1};
    tbl[5] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0};
    tbl[6] = '{a: 8'd13,  b: 8'd4,   q: 8'd3,   r: 8'd1,   z: 1'b0};
    tbl[7] = '{a: 8'd1,   b: 8'd0,   q: 8'd255, r: 8'd1,   z: 1'b1};
    tbl[8] = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0,   z: 1'b0};
    tbl[9] = '{a: 8'd254, b: 8'd127, q: 8'd2,   r: 8'd0,   z: 1'b0};

    // Reset state, asserted without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset quotient", 32'(bus.quotient), 32'd0);
    check("reset remainder", 32'(bus.remainder), 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 32'(bus.in_ready), 32'd1);

    // 200/7 with operand noise during CALC that must be ignored.
    apply(8'd200, 8'd7);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd3;
    bus.divisor  = 8'd1;
    wait_valid(lat, busy_ok);
    bus.in_valid = 1'b0;
    check("200/7 in_ready low in CALC", 32'(busy_ok), 32'd1);
    check_result("200/7", '{a: 8'd200, b: 8'd7, q: 8'd28, r: 8'd4, z: 1'b0}, lat, 8);
    consume("200/7");

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("%0d/%0d", tbl[i].a, tbl[i].b);
      apply(tbl[i].a, tbl[i].b);
      wait_valid(lat, busy_ok);
      check({tag, " in_ready low in CALC"}, 32'(busy_ok), 32'd1);
      check_result(tag, tbl[i], lat, tbl[i].z ? 0 : 8);
      consume(tag);
    end

    // Backpressure, then a same-edge accept as the result drains.
    apply(8'd200, 8'd7);
    wait_valid(lat, busy_ok);
    check_result("bp 200/7", '{a: 8'd200, b: 8'd7, q: 8'd28, r: 8'd4, z: 1'b0}, lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp hold %0d in_ready", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp hold %0d quotient", i), 32'(bus.quotient), 32'd28);
      check($sformatf("bp hold %0d remainder", i), 32'(bus.remainder), 32'd4);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'd77;
    bus.divisor   = 8'd10;
    #1 check("b2b in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    wait_valid(lat, busy_ok);
    check("77/10 in_ready low in CALC", 32'(busy_ok), 32'd1);
    check_result("77/10", '{a: 8'd77, b: 8'd10, q: 8'd7, r: 8'd7, z: 1'b0}, lat, 8);
    consume("77/10");

    // Reset during step 4 of 200/7: outputs drop with no clock edge.
    apply(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd0);
    check("midreset quotient", 32'(bus.quotient), 32'd0);
    check("midreset remainder", 32'(bus.remainder), 32'd0);
    check("midreset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    apply(8'd50, 8'd6);
    wait_valid(lat, busy_ok);
    check_result("50/6", '{a: 8'd50, b: 8'd6, q: 8'd8, r: 8'd2, z: 1'b0}, lat, 8);
    consume("50/6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
